mips_id_ex_stage: RTL
=====================

# mips_id_ex_stage

ID/EX pipeline stage of the five-stage MIPS core. It latches decoded operands and control from the decode stage into the execute stage that feeds the forwarding unit. It detects load-use hazards and freezes PC and IF/ID for one cycle while inserting a bubble. It also accepts a flush from branch resolution.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register-index width
- ALUOP_W, 4, ALU opcode width

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  DATA_W  PC of decode instruction
- id_rs, id_rt, id_rd  in  REG_AW  source/destination indices
- id_uses_rt  in  1  instruction reads rt (R-type, store, beq)
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1  control bits
- id_alu_op  in  ALUOP_W  ALU operation
- flush  in  1  branch taken in EX; squash decode slot
- pc_write  out  1  0 freezes PC (combinational)
- if_id_write  out  1  0 freezes IF/ID (combinational)
- ex_valid  out  1  execute slot valid
- ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
- ex_rs, ex_rt, ex_dest  out  REG_AW  registered indices; ex_dest = id_reg_dst ? id_rd : id_rt
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1  registered control
- ex_alu_op  out  ALUOP_W  registered ALU op

## Operation
- Load-use hazard: hazard = ex_valid & ex_mem_read & ex_dest != 0 & id_valid & (ex_dest == id_rs | (id_uses_rt & ex_dest == id_rt)).
- pc_write = if_id_write = ~hazard, except both are 1 when flush is 1.
- Next-state priority: flush > hazard > load.
  - flush: ex_valid <= 0, all control bits <= 0.
  - hazard: bubble; ex_valid <= 0, control <= 0, data fields don't-care (hold).
  - otherwise: capture all id_* fields; ex_valid <= id_valid; if !id_valid, control <= 0.
- A bubble clears ex_mem_read, so a hazard lasts exactly one cycle per load.
- Register $0 as destination never creates a hazard; ex_reg_write is forced 0 when ex_dest == 0.
- No arithmetic in the block; ex_dest is the mux only.

## Timing
- Reset (async assert, sync-safe deassert): every ex_* output 0. pc_write = if_id_write = 1, since ex_valid = 0.
- Latency: decode inputs appear on ex_* one clock after the sampling edge.
- hazard/pc_write/if_id_write are combinational from current ex_* and id_* inputs. They are valid before the same edge.
- flush and hazard in the same cycle: flush wins, no stall, bubble inserted.
- Reset mid-stall: stall is released immediately because ex_valid goes to 0.
- Back-to-back loads with no dependency: no stall.

## Configuration
- MIPS_HAZARD_STATS_EN defined:
  - Adds outputs stall_count and flush_count, 32 bits each.
  - Each counter increments on a clock edge where hazard (resp. flush) is 1, and saturates at 0xFFFFFFFF.
  - Both counters are cleared by rst_n.
- Undefined: the outputs and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package mips_pkg holds:
  - DATA_W, REG_AW, ALUOP_W defaults
  - ALU opcode constants
  - a packed control struct (reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst) used by ID, ID/EX, EX/MEM
- One sub-module: mips_load_use_detect. It is purely combinational and computes hazard from the ex_*/id_* fields. It is reused later by a branch-in-ID hazard extension.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → all ex_* = 0, pc_write=1, if_id_write=1.
- Pass-through: id_valid=1, add $3,$1,$2 (rs=1, rt=2, rd=3, reg_dst=1) with rs_data=5, rt_data=7 → next cycle ex_dest=3, ex_rs_data=5, ex_rt_data=7, ex_valid=1.
- Load-use: lw $2,0($1) followed by add $4,$2,$3 → one cycle pc_write=0 and ex_valid=0 bubble, then add enters EX; no second stall.
- $0 / rt unused: lw $0 then add using $0 → no stall; lw $5 then addi $6,$5,1 (uses_rt=0, rs=5) → stall; lw $5 then addi $6,$7,1 → no stall.
- Flush priority: hazard condition with flush=1 → pc_write=1, next ex_valid=0, all control 0.
- With MIPS_HAZARD_STATS_EN: three load-use pairs and two flushes → stall_count=3, flush_count=2. Preloaded 0xFFFFFFFF stays saturated.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, ALU opcodes, control bundle.
// Latency: n/a (package only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    // ALU operation encodings driven by the decoder, consumed by EX.
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 4'd12;

    // Control bundle carried ID -> ID/EX -> EX/MEM.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_dst;
    } ctrl_t;

    // Destination register select: rd for R-type, rt otherwise.
    function automatic logic [REG_AW-1:0] sel_dest(input logic             reg_dst,
                                                   input logic [REG_AW-1:0] rd,
                                                   input logic [REG_AW-1:0] rt);
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/mips_load_use_detect.sv
// Load-use hazard detector: flags a decode instruction reading the register a load in EX writes.
// Latency: purely combinational.
// Backpressure: none; the hazard output is what the caller uses to stall.
// Ports: ex_* describe the instruction in EX, id_* the one in decode; hazard_o is the stall request.
module mips_load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_dest_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    output logic              hazard_o
);

    // $0 is never written, so a load targeting it cannot create a dependency.
    assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_dest_i != '0) & id_valid_i &
                      ((ex_dest_i == id_rs_i) | (id_uses_rt_i & (ex_dest_i == id_rt_i)));

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch flush.
// Latency: 1 cycle from decode inputs to ex_* outputs; pc_write/if_id_write combinational.
// Backpressure: on load-use hazard freezes PC and IF/ID one cycle and injects a bubble; flush overrides.
// Ports: id_* decode fields in, ex_* registered execute fields out, flush from branch resolution.
// Optional: define MIPS_HAZARD_STATS_EN to add stall_count/flush_count saturating counters.
module mips_id_ex_stage #(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int REG_AW  = mips_pkg::REG_AW,
    parameter int ALUOP_W = mips_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_uses_rt,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               flush,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_dest,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
`ifdef MIPS_HAZARD_STATS_EN
    output logic [31:0]        stall_count,
    output logic [31:0]        flush_count,
`endif
    output logic [ALUOP_W-1:0] ex_alu_op
);

    import mips_pkg::*;

    ctrl_t               id_ctrl;
    logic [REG_AW-1:0]   id_dest;
    logic                hazard;

    logic                ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0]   ex_pc_q, ex_pc_d;
    logic [DATA_W-1:0]   ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0]   ex_rt_data_q, ex_rt_data_d;
    logic [DATA_W-1:0]   ex_imm_q, ex_imm_d;
    logic [REG_AW-1:0]   ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0]   ex_rt_q, ex_rt_d;
    logic [REG_AW-1:0]   ex_dest_q, ex_dest_d;
    logic                ex_reg_write_q, ex_reg_write_d;
    logic                ex_mem_read_q, ex_mem_read_d;
    logic                ex_mem_write_q, ex_mem_write_d;
    logic                ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic                ex_alu_src_q, ex_alu_src_d;
    logic [ALUOP_W-1:0]  ex_alu_op_q, ex_alu_op_d;

    assign id_ctrl = '{reg_write:  id_reg_write,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg,
                       alu_src:    id_alu_src,
                       reg_dst:    id_reg_dst};
    assign id_dest = sel_dest(id_ctrl.reg_dst, id_rd, id_rt);

    mips_load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ex_mem_read_q),
        .ex_dest_i     (ex_dest_q),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .hazard_o      (hazard)
    );

    // A flush squashes the decode slot, so stalling it would be pointless.
    assign pc_write    = ~hazard | flush;
    assign if_id_write = ~hazard | flush;

    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_pc_d         = ex_pc_q;
        ex_rs_data_d    = ex_rs_data_q;
        ex_rt_data_d    = ex_rt_data_q;
        ex_imm_d        = ex_imm_q;
        ex_rs_d         = ex_rs_q;
        ex_rt_d         = ex_rt_q;
        ex_dest_d       = ex_dest_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        ex_mem_write_d  = ex_mem_write_q;
        ex_mem_to_reg_d = ex_mem_to_reg_q;
        ex_alu_src_d    = ex_alu_src_q;
        ex_alu_op_d     = ex_alu_op_q;
        if (flush || hazard) begin
            // Bubble: data fields hold, only validity and control are cleared.
            // Clearing mem_read is what limits a load-use stall to one cycle.
            ex_valid_d      = 1'b0;
            ex_reg_write_d  = 1'b0;
            ex_mem_read_d   = 1'b0;
            ex_mem_write_d  = 1'b0;
            ex_mem_to_reg_d = 1'b0;
            ex_alu_src_d    = 1'b0;
            ex_alu_op_d     = '0;
        end else begin
            ex_valid_d      = id_valid;
            ex_pc_d         = id_pc;
            ex_rs_data_d    = id_rs_data;
            ex_rt_data_d    = id_rt_data;
            ex_imm_d        = id_imm;
            ex_rs_d         = id_rs;
            ex_rt_d         = id_rt;
            ex_dest_d       = id_dest;
            // Writes to $0 are dropped here so later stages need no special case.
            ex_reg_write_d  = id_valid & id_ctrl.reg_write & (id_dest != '0);
            ex_mem_read_d   = id_valid & id_ctrl.mem_read;
            ex_mem_write_d  = id_valid & id_ctrl.mem_write;
            ex_mem_to_reg_d = id_valid & id_ctrl.mem_to_reg;
            ex_alu_src_d    = id_valid & id_ctrl.alu_src;
            ex_alu_op_d     = id_valid ? id_alu_op : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= '0;
            ex_rs_data_q    <= '0;
            ex_rt_data_q    <= '0;
            ex_imm_q        <= '0;
            ex_rs_q         <= '0;
            ex_rt_q         <= '0;
            ex_dest_q       <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_alu_op_q     <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_q         <= ex_pc_d;
            ex_rs_data_q    <= ex_rs_data_d;
            ex_rt_data_q    <= ex_rt_data_d;
            ex_imm_q        <= ex_imm_d;
            ex_rs_q         <= ex_rs_d;
            ex_rt_q         <= ex_rt_d;
            ex_dest_q       <= ex_dest_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_alu_op_q     <= ex_alu_op_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs_data    = ex_rs_data_q;
    assign ex_rt_data    = ex_rt_data_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign ex_dest       = ex_dest_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_mem_to_reg = ex_mem_to_reg_q;
    assign ex_alu_src    = ex_alu_src_q;
    assign ex_alu_op     = ex_alu_op_q;

`ifdef MIPS_HAZARD_STATS_EN
    logic [31:0] stall_count_q, flush_count_q;

    // Raw hazard is counted even when a flush overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (hazard && (stall_count_q != '1)) stall_count_q <= stall_count_q + 32'd1;
            if (flush  && (flush_count_q != '1)) flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
